// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Data-memory bus between the load/store unit and the memory slave.
//            Word-addressed request carrying byte enables and lane-replicated
//            write data; bus_ready completes a transfer while bus_req is high.
// Signals  : bus_req   - request, held until the transfer completes or times out
//            bus_we    - 1 = write, 0 = read
//            bus_addr  - word address (low two bits always zero)
//            bus_be    - byte enables, lane i = bits 8i+7:8i
//            bus_wdata - store data, replicated across lanes
//            bus_rdata - read data, valid while bus_ready is high
//            bus_ready - transfer completion from the slave
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Byte/halfword/word loads and stores with RISC-V funct3 semantics
//            between the core datapath and the data-memory bus. Generates byte
//            enables and lane-replicated store data, sign/zero-extends loads,
//            runs a req/ready handshake with a timeout and stalls the core
//            until each access completes.
// Ports    : clk       - rising-edge clock
//            reset     - synchronous, active-low reset
//            MemRead   - load request
//            MemWrite  - store request (wins when both are set)
//            Funct3    - access size / signedness
//            Addr      - byte address
//            WrData    - store data
//            LoadData  - extended load result, held outside the DONE cycle
//            Stall     - hold PC and register writes
//            Fault     - one-cycle pulse: misaligned address or illegal funct3
//            BusErr    - one-cycle pulse: bus timeout
//            bus       - data-memory bus (master side)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [2:0]               Funct3,
  input  logic [31:0]              Addr,
  input  logic [31:0]              WrData,
  output logic [31:0]              LoadData,
  output logic                     Stall,
  output logic                     Fault,
  output logic                     BusErr,
  load_store_unit_if.master        bus
);

  localparam int              CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   C_TMO_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_REQ  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   load_q, load_d;
  logic          fault_q, fault_d;
  logic          buserr_q, buserr_d;

  // Request decode from the live core inputs (used only in IDLE)
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_f3_ok;
  logic        w_align_ok;
  logic        w_legal;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WrData;
    unique case (Funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << Addr[1:0];
        w_wdata = {4{WrData[7:0]}};
      end
      2'b01: begin
        w_be    = Addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WrData[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase

    if (MemWrite) w_f3_ok = (Funct3[2] == 1'b0) && (Funct3[1:0] != 2'b11);
    else          w_f3_ok = (Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

    unique case (Funct3[1:0])
      2'b01:   w_align_ok = (Addr[0] == 1'b0);
      2'b10:   w_align_ok = (Addr[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  assign w_legal = w_f3_ok && w_align_ok;

  // Lane selection and extension of the returning read data
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  always_comb begin
    w_byte = bus.bus_rdata[{off_q, 3'b000} +: 8];
    w_half = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    unique case (f3_q)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = bus.bus_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= C_IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      cnt_q    <= '0;
      load_q   <= 32'd0;
      fault_q  <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      fault_q  <= fault_d;
      buserr_q <= buserr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    fault_d  = 1'b0;
    buserr_d = 1'b0;
    unique case (state_q)
      C_IDLE: begin
        if (MemRead || MemWrite) begin
          we_d    = MemWrite;
          f3_d    = Funct3;
          off_d   = Addr[1:0];
          addr_d  = {Addr[31:2], 2'b00};
          be_d    = w_be;
          wdata_d = w_wdata;
          cnt_d   = '0;
          if (w_legal) begin
            state_d = C_REQ;
          end else begin
            // Rejected without touching the bus
            state_d = C_DONE;
            fault_d = 1'b1;
            if (!MemWrite) load_d = 32'd0;
          end
        end
      end
      C_REQ: begin
        if (bus.bus_ready) begin
          state_d = C_DONE;
          if (!we_q) load_d = w_ext;
        end else if (cnt_q == C_TMO_LAST) begin
          state_d  = C_DONE;
          buserr_d = 1'b1;
          load_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // One cycle with Stall low lets the core retire the instruction
      // before IDLE samples the request lines again.
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Stall = (state_q == C_REQ) || ((state_q == C_IDLE) && (MemRead || MemWrite));
  end

  assign bus.bus_req   = (state_q == C_REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign LoadData      = load_q;
  assign Fault         = fault_q;
  assign BusErr        = buserr_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit (TIMEOUT = 4). Each access
//            pushes its expected outcome to a scoreboard queue; the entry is
//            popped and compared when the DUT reaches its completion cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] LoadData;
  logic        Stall;
  logic        Fault;
  logic        BusErr;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Funct3   (Funct3),
    .Addr     (Addr),
    .WrData   (WrData),
    .LoadData (LoadData),
    .Stall    (Stall),
    .Fault    (Fault),
    .BusErr   (BusErr),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        chk_load;
    logic [31:0] load;
    logic        fault;
    logic        buserr;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic chk_wdata,
                              input logic chk_load, input logic [31:0] load,
                              input logic fault, input logic buserr,
                              input int stalls, input int reqs);
    exp_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.chk_wdata = chk_wdata;
    e.chk_load = chk_load; e.load = load; e.fault = fault; e.buserr = buserr;
    e.stalls = stalls; e.reqs = reqs;
    return e;
  endfunction

  // ready_at: REQ cycle (1-based) in which bus_ready is presented; 0 = never
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdata, input int ready_at, input exp_t e);
    exp_t cur;
    int   stalls;
    int   reqs;
    bit   done;
    sb.push_back(e);
    @(negedge clk);
    MemRead  = rd;
    MemWrite = wr;
    Funct3   = f3;
    Addr     = a;
    WrData   = wd;
    bus_if.bus_rdata = rdata;
    bus_if.bus_ready = 1'b0;
    #1;
    stalls = Stall ? 1 : 0;
    reqs   = 0;
    done   = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus_if.bus_req) begin
        reqs++;
        if (reqs == 1) begin
          check_val("bus_we", bus_if.bus_we, sb[0].we);
          check_val("bus_addr", bus_if.bus_addr, sb[0].addr);
          check_val("bus_be", bus_if.bus_be, sb[0].be);
          if (sb[0].chk_wdata) check_val("bus_wdata", bus_if.bus_wdata, sb[0].wdata);
        end
        bus_if.bus_ready = (reqs == ready_at);
      end else begin
        bus_if.bus_ready = 1'b0;
      end
      if (Stall) stalls++;
      else       done = 1'b1;
    end
    check_val("done_reached", done, 1);
    cur = sb.pop_front();
    check_val("stall_cycles", stalls, cur.stalls);
    check_val("req_cycles", reqs, cur.reqs);
    check_val("fault", Fault, cur.fault);
    check_val("buserr", BusErr, cur.buserr);
    check_val("req_low_done", bus_if.bus_req, 0);
    if (cur.chk_load) check_val("load_data", LoadData, cur.load);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    bus_if.bus_ready = 1'b0;
    @(negedge clk);
    check_val("fault_pulse_end", Fault, 0);
    check_val("buserr_pulse_end", BusErr, 0);
    check_val("stall_idle", Stall, 0);
    if (cur.chk_load) check_val("load_hold", LoadData, cur.load);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Funct3   = 3'd0;
    Addr     = 32'd0;
    WrData   = 32'd0;
    bus_if.bus_rdata = 32'd0;
    bus_if.bus_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_load", LoadData, 0);
    check_val("rst_stall", Stall, 0);
    check_val("rst_fault", Fault, 0);
    check_val("rst_buserr", BusErr, 0);
    check_val("rst_req", bus_if.bus_req, 0);
    check_val("rst_we", bus_if.bus_we, 0);
    check_val("rst_be", bus_if.bus_be, 0);
    check_val("rst_addr", bus_if.bus_addr, 0);
    check_val("rst_wdata", bus_if.bus_wdata, 0);
    reset = 1'b1;

    // LW with two wait states
    run_access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3,
               mk(0, 32'h100, 4'b1111, 0, 0, 1, 32'hDEADBEEF, 0, 0, 4, 3));
    // Byte / halfword loads from 0x80123456
    run_access(1, 0, 3'b000, 32'h103, 0, 32'h80123456, 1,
               mk(0, 32'h100, 4'b1000, 0, 0, 1, 32'hFFFFFF80, 0, 0, 2, 1));
    run_access(1, 0, 3'b100, 32'h103, 0, 32'h80123456, 1,
               mk(0, 32'h100, 4'b1000, 0, 0, 1, 32'h00000080, 0, 0, 2, 1));
    run_access(1, 0, 3'b001, 32'h102, 0, 32'h80123456, 1,
               mk(0, 32'h100, 4'b1100, 0, 0, 1, 32'hFFFF8012, 0, 0, 2, 1));
    run_access(1, 0, 3'b101, 32'h100, 0, 32'h80123456, 2,
               mk(0, 32'h100, 4'b0011, 0, 0, 1, 32'h00003456, 0, 0, 3, 2));
    run_access(1, 0, 3'b000, 32'h101, 0, 32'h0000F100, 1,
               mk(0, 32'h100, 4'b0010, 0, 0, 1, 32'hFFFFFFF1, 0, 0, 2, 1));
    // Stores
    run_access(0, 1, 3'b001, 32'h102, 32'h00001234, 0, 1,
               mk(1, 32'h100, 4'b1100, 32'h12341234, 1, 0, 0, 0, 0, 2, 1));
    run_access(0, 1, 3'b000, 32'h101, 32'h000000AB, 0, 1,
               mk(1, 32'h100, 4'b0010, 32'hABABABAB, 1, 0, 0, 0, 0, 2, 1));
    run_access(0, 1, 3'b010, 32'h104, 32'h11223344, 0, 2,
               mk(1, 32'h104, 4'b1111, 32'h11223344, 1, 0, 0, 0, 0, 3, 2));
    // Faults: misaligned LW, illegal load funct3, misaligned SH, illegal store funct3
    run_access(1, 0, 3'b010, 32'h101, 0, 32'h12345678, 1,
               mk(0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 1, 0));
    run_access(1, 0, 3'b011, 32'h100, 0, 32'h12345678, 1,
               mk(0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 1, 0));
    run_access(0, 1, 3'b001, 32'h103, 32'h5555, 0, 1,
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    run_access(0, 1, 3'b100, 32'h100, 32'h5555, 0, 1,
               mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    // Good load, then a timed-out load clears LoadData
    run_access(1, 0, 3'b010, 32'h200, 0, 32'hCAFEF00D, 1,
               mk(0, 32'h200, 4'b1111, 0, 0, 1, 32'hCAFEF00D, 0, 0, 2, 1));
    run_access(1, 0, 3'b010, 32'h200, 0, 32'hCAFEF00D, 0,
               mk(0, 32'h200, 4'b1111, 0, 0, 1, 32'h0, 0, 1, 5, 4));

    // bus_ready with no request outstanding must not start anything
    @(negedge clk);
    bus_if.bus_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_val("idle_ready_req", bus_if.bus_req, 0);
      check_val("idle_ready_stall", Stall, 0);
    end
    bus_if.bus_ready = 1'b0;
    run_access(1, 0, 3'b010, 32'h300, 0, 32'h0BADF00D, 2,
               mk(0, 32'h300, 4'b1111, 0, 0, 1, 32'h0BADF00D, 0, 0, 3, 2));

    // Reset in the middle of a request
    @(negedge clk);
    MemRead = 1'b1;
    Funct3  = 3'b010;
    Addr    = 32'h100;
    bus_if.bus_ready = 1'b0;
    @(negedge clk);
    check_val("mid_req_up", bus_if.bus_req, 1);
    @(negedge clk);
    reset   = 1'b0;
    MemRead = 1'b0;
    @(negedge clk);
    check_val("mid_rst_req", bus_if.bus_req, 0);
    check_val("mid_rst_stall", Stall, 0);
    check_val("mid_rst_load", LoadData, 0);
    check_val("mid_rst_be", bus_if.bus_be, 0);
    check_val("mid_rst_addr", bus_if.bus_addr, 0);
    reset = 1'b1;

    // Read and write requested together: the write is issued
    run_access(1, 1, 3'b010, 32'h108, 32'h55AA55AA, 0, 1,
               mk(1, 32'h108, 4'b1111, 32'h55AA55AA, 1, 0, 0, 0, 0, 2, 1));

    check_val("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
